// File: rtl/nes_controller_emulator.sv
// -----------------------------------------------------------------------------
// nes_controller_emulator
//
// Emulates an NES (or SNES) game controller on the console side of the cable.
// The console strobes nes_latch to capture the button state, then clocks the
// bits out one at a time on nes_clk; nes_data is active-low (0 = pressed).
// Both console signals are asynchronous to clk and are synchronised
// internally before use.
//
// Configuration macro:
//   NES_CONTROLLER_EMULATOR_SNES_EN  defined   -> 16-bit SNES frame
//                                    undefined -> 8-bit NES frame (default)
//
// Parameters:
//   SYNC_STAGES  synchroniser depth on nes_latch / nes_clk (2..3)
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       synchronous active-low reset
//   buttons     button states, 1 = pressed (NES uses [7:0], SNES [11:0])
//   nes_latch   console latch strobe (async)
//   nes_clk     console shift clock (async)
//   nes_data    registered serial data to the console, 0 = pressed
//   frame_done  one-cycle pulse when the last frame bit is presented
//   bit_index   shifts completed in the current frame, saturating
// -----------------------------------------------------------------------------
module nes_controller_emulator #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] buttons,
  input  logic        nes_latch,
  input  logic        nes_clk,
  output logic        nes_data,
  output logic        frame_done,
  output logic [4:0]  bit_index
);

`ifdef NES_CONTROLLER_EMULATOR_SNES_EN
  localparam int FRAME_LEN = 16;
`else
  localparam int FRAME_LEN = 8;
`endif

  localparam logic [4:0] LAST_IDX = 5'(FRAME_LEN - 1);
  localparam logic [4:0] SAT_IDX  = 5'(FRAME_LEN);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t                 state, state_next;
  logic [FRAME_LEN-1:0]   shift_reg, shift_next;
  logic [FRAME_LEN-1:0]   load_vec;
  logic                   data_next;
  logic                   done_next;
  logic [4:0]             index_next;

  logic [SYNC_STAGES-1:0] latch_sync, clk_sync;
  logic                   latch_prev, clk_prev;
  logic                   latch_s, clk_s;
  logic                   latch_rise, clk_rise;

  // Frame image as the console will see it: active-low buttons, and on SNES
  // the four trailing controller-ID bits read as released.
  // shift_reg[0] is never read: nes_data is registered alongside the shift
  // register and already carries the bit being presented.
`ifdef NES_CONTROLLER_EMULATOR_SNES_EN
  assign load_vec = {4'hF, ~buttons};
  logic unused_sink;
  assign unused_sink = &{1'b0, shift_reg[0]};
`else
  assign load_vec = ~buttons[7:0];
  logic unused_sink;
  assign unused_sink = &{1'b0, buttons[11:8], shift_reg[0]};
`endif

  // ---------------------------------------------------------------------------
  // Synchronisers and edge-detect flops
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which is what makes the chain a
  // chain rather than a single wire.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      latch_sync <= '0;
      clk_sync   <= '0;
      latch_prev <= 1'b0;
      clk_prev   <= 1'b0;
    end else begin
      latch_sync <= {latch_sync[SYNC_STAGES-2:0], nes_latch};
      clk_sync   <= {clk_sync[SYNC_STAGES-2:0], nes_clk};
      latch_prev <= latch_s;
      clk_prev   <= clk_s;
    end
  end

  assign latch_s    = latch_sync[SYNC_STAGES-1];
  assign clk_s      = clk_sync[SYNC_STAGES-1];
  assign latch_rise = latch_s & ~latch_prev;
  // Shift clocks are only honoured while the latch is low; this also makes a
  // simultaneous latch rise win over a clock rise.
  assign clk_rise   = clk_s & ~clk_prev & ~latch_s;

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first so no path through
  // the case leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    shift_next = shift_reg;
    data_next  = nes_data;
    index_next = bit_index;
    done_next  = 1'b0;

    if (latch_rise) begin
      // Load on the detect cycle itself so nes_data moves SYNC_STAGES+1
      // cycles after the pin edge; any frame in progress is dropped silently.
      state_next = LOAD;
      shift_next = load_vec;
      data_next  = load_vec[0];
      index_next = '0;
    end else begin
      unique case (state)
        IDLE: ;
        LOAD: begin
          if (!latch_s) begin
            // Latch has fallen: keep the snapshot taken last cycle.
            state_next = SHIFT;
          end else begin
            shift_next = load_vec;
            data_next  = load_vec[0];
            index_next = '0;
          end
        end
        SHIFT: begin
          if (clk_rise) begin
            shift_next = {1'b1, shift_reg[FRAME_LEN-1:1]};
            data_next  = shift_reg[1];
            index_next = bit_index + 5'd1;
            if (bit_index == LAST_IDX - 5'd1) begin
              done_next  = 1'b1;
              state_next = DONE;
            end
          end
        end
        DONE: begin
          // A real controller's shift register drains to 0 past the frame,
          // which the console reads as "pressed".
          if (clk_rise) begin
            data_next = 1'b0;
            if (bit_index != SAT_IDX) begin
              index_next = bit_index + 5'd1;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      shift_reg  <= '1;
      nes_data   <= 1'b1;
      frame_done <= 1'b0;
      bit_index  <= '0;
    end else begin
      state      <= state_next;
      shift_reg  <= shift_next;
      nes_data   <= data_next;
      frame_done <= done_next;
      bit_index  <= index_next;
    end
  end

endmodule

// File: doc/nes_controller_emulator.md
NES_CONTROLLER_EMULATOR -- requirements
Module: nes_controller_emulator

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of synchroniser flops on nes_latch and nes_clk (legal range 2-3).
REQ-002 SHALL have port clk, input, 1: system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port buttons, input, 12: button states, 1 = pressed.
  - NES order: [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right.
  - SNES order: [0]B [1]Y [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right [8]A [9]X [10]L [11]R.
REQ-005 SHALL have port nes_latch, input, 1: console latch, asynchronous to clk.
REQ-006 SHALL have port nes_clk, input, 1: console shift clock, asynchronous to clk.
REQ-007 SHALL have port nes_data, output, 1: serial data, registered; 0 = pressed, 1 = released.
REQ-008 SHALL have port frame_done, output, 1: one-cycle pulse when the last frame bit has been shifted.
REQ-009 SHALL have port bit_index, output, 5: number of shifts completed in the current frame, saturating.

Function
REQ-010 SHALL pass nes_latch and nes_clk each through SYNC_STAGES flops, then one edge-detect flop; rising edge = synchronised value high and its previous value low.
REQ-011 SHALL implement a state machine with states IDLE, LOAD, SHIFT and DONE.
REQ-012 IDLE: latch rise -> LOAD; clock edges ignored.
REQ-013 LOAD: every cycle, the shift register SHALL load the inverted buttons, nes_data SHALL equal the inverted bit 0, and bit_index SHALL be 0.
REQ-014 LOAD: latch fall -> SHIFT; the register SHALL hold the value loaded in the previous cycle.
REQ-015 SHIFT: each nes_clk rising edge SHALL shift the register one place toward bit 0, fill with 1, update nes_data to the new bit 0, and increment bit_index.
REQ-016 SHIFT: when bit_index reaches FRAME_LEN-1, frame_done SHALL pulse for one cycle and the state SHALL go to DONE; FRAME_LEN is 8 (NES) or 16 (SNES).
REQ-017 DONE: nes_clk edges SHALL hold nes_data at 0 (bits past the frame read as "pressed"/1 at the console), bit_index SHALL saturate at FRAME_LEN, and frame_done SHALL NOT pulse again.
REQ-018 A latch rise in any state SHALL force LOAD on the next cycle, aborting any frame in progress without a frame_done pulse.
REQ-019 A latch rise and a clock rise detected in the same cycle: the latch SHALL win and the clock edge SHALL be discarded.
REQ-020 Clock edges while the synchronised latch is high SHALL be ignored.
REQ-021 buttons changes outside LOAD SHALL have no effect on the frame in progress.
REQ-022 nes_data SHALL change exactly SYNC_STAGES+1 clk cycles after the nes_latch or nes_clk pin edge, provided the edge meets setup.
REQ-023 Console edges less than SYNC_STAGES+2 clk cycles apart are unsupported; behaviour for them is not defined.

Reset
REQ-024 While rst_n is low at a clk edge, the following SHALL apply:
  - state = IDLE;
  - nes_data = 1;
  - frame_done = 0;
  - bit_index = 0;
  - shift register all 1s;
  - all synchroniser and edge flops = 0.
REQ-025 Reset asserted mid-frame SHALL discard the frame; after release, the next frame SHALL start only on a new latch rise.

Configuration
REQ-026 Macro NES_CONTROLLER_EMULATOR_SNES_EN SHALL select the frame format.
  - Defined: FRAME_LEN = 16; register bits 0-11 = inverted buttons[11:0]; bits 12-15 = 1 (controller ID).
  - Undefined: FRAME_LEN = 8; register = inverted buttons[7:0]; buttons[11:8] unused; saturation value 8.

Verification
REQ-027 NES build, buttons=12'h009 (A, Start): latch pulse, then 8 nes_clk pulses -> nes_data sequence 0,1,1,0,1,1,1,1 sampled after latch fall and after pulses 1-7; frame_done pulses once after pulse 7.
REQ-028 NES build, buttons=0: latch, then 10 clock pulses -> nes_data 1 for bits 0-7, then 0 after pulses 8-10; bit_index = 8; frame_done pulses only once.
REQ-029 NES build: latch, 3 clock pulses, buttons changed, new latch -> no frame_done; nes_data reflects the new buttons bit 0 within SYNC_STAGES+1 cycles.
REQ-030 nes_latch and nes_clk rise at the same clk edge -> LOAD entered; bit_index = 0; no shift occurs.
REQ-031 SNES build, buttons=12'h800 (R): latch plus 16 pulses -> nes_data low only at bit 11; bits 12-15 read 1; frame_done after pulse 15.
REQ-032 rst_n low for one cycle during SHIFT (bit_index = 4) -> next cycle nes_data = 1, bit_index = 0, state IDLE; clock pulses ignored until the next latch.
